// File: rtl/cpu_bus_pkg.sv
// Shared encodings for the core-side SRAM-like request bus and the requester ids used by the arbiter.
// Combinational helpers only; no latency or flow control of its own.
package cpu_bus_pkg;

    localparam int SRAM_AW = 32;
    localparam int SRAM_DW = 32;

    typedef logic req_id_t;

    localparam req_id_t ID_INST = 1'b0;
    localparam req_id_t ID_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // With no contention the only requester wins; under round-robin a tie goes to whoever was not served last.
    function automatic req_id_t pick_grant(input logic    rr_en,
                                           input logic    inst_req,
                                           input logic    data_req,
                                           input req_id_t rr_last);
        if (rr_en && inst_req && data_req) begin
            return (rr_last == ID_INST) ? ID_DATA : ID_INST;
        end
        return data_req ? ID_DATA : ID_INST;
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// Ring of 1-bit requester ids in acceptance order; push/pop act on the clock edge, head is read combinationally.
// Zero latency; a push while full or a pop while empty is dropped, the caller gates both.
module arb_id_fifo
    import cpu_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push_i,
    input  req_id_t                  push_id_i,
    input  logic                     pop_i,
    output req_id_t                  head_id_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] ring_q, ring_d;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o    = (cnt_q == CW'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign count_o   = cnt_q;
    assign head_id_o = ring_q[rptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        ring_d = ring_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_ok) begin
            ring_d[wptr_q] = push_id_i;
            wptr_d         = wptr_q + PW'(1);
        end
        if (pop_ok) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ring_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            ring_q <= ring_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between fetch and MEM requesters and steers in-order responses back by id.
// Zero added latency on both paths; stalls both requesters when MAX_OUTS transactions are outstanding.
module sram_req_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int MAX_OUTS = 4,
    parameter bit RR       = 1'b0
) (
    input  logic                      clk,
    input  logic                      resetn,

    input  logic                      inst_req,
    input  logic [1:0]                inst_size,
    input  logic [SRAM_AW-1:0]        inst_addr,
    output logic                      inst_addr_ok,
    output logic                      inst_data_ok,
    output logic [SRAM_DW-1:0]        inst_rdata,

    input  logic                      data_req,
    input  logic                      data_wr,
    input  logic [1:0]                data_size,
    input  logic [SRAM_AW-1:0]        data_addr,
    input  logic [3:0]                data_wstrb,
    input  logic [SRAM_DW-1:0]        data_wdata,
    output logic                      data_addr_ok,
    output logic                      data_data_ok,
    output logic [SRAM_DW-1:0]        data_rdata,

    output logic                      out_req,
    output logic                      out_wr,
    output logic [1:0]                out_size,
    output logic [SRAM_AW-1:0]        out_addr,
    output logic [3:0]                out_wstrb,
    output logic [SRAM_DW-1:0]        out_wdata,
    input  logic                      out_addr_ok,
    input  logic                      out_data_ok,
    input  logic [SRAM_DW-1:0]        out_rdata,

    output logic [$clog2(MAX_OUTS):0] outs_cnt,
    output logic                      proto_err
);

    logic    lock_valid_q, lock_valid_d;
    req_id_t lock_id_q, lock_id_d;
    req_id_t rr_last_q, rr_last_d;
    logic    proto_err_q, proto_err_d;

    req_id_t grant;
    logic    gnt_req;
    logic    full;
    logic    empty;
    req_id_t head_id;
    logic    accept;
    logic    resp;
    logic    pop;

    always_comb begin
        if (lock_valid_q) begin
            grant = lock_id_q;
        end else begin
            grant = pick_grant(RR, inst_req, data_req, rr_last_q);
        end
    end

    assign gnt_req = (grant == ID_DATA) ? data_req : inst_req;

    // Qualifying with resetn keeps every output at zero while reset is held.
    assign out_req = resetn & gnt_req & ~full;
    assign accept  = out_req & out_addr_ok;

    always_comb begin
        out_wr    = 1'b0;
        out_size  = '0;
        out_addr  = '0;
        out_wstrb = '0;
        out_wdata = '0;
        if (resetn) begin
            if (grant == ID_DATA) begin
                out_wr    = data_wr;
                out_size  = data_size;
                out_addr  = data_addr;
                out_wstrb = data_wstrb;
                out_wdata = data_wdata;
            end else begin
                out_size  = inst_size;
                out_addr  = inst_addr;
            end
        end
    end

    assign inst_addr_ok = accept & (grant == ID_INST);
    assign data_addr_ok = accept & (grant == ID_DATA);

    assign resp = resetn & out_data_ok;
    assign pop  = resp & ~empty;

    assign inst_data_ok = pop & (head_id == ID_INST);
    assign data_data_ok = pop & (head_id == ID_DATA);
    assign inst_rdata   = resetn ? out_rdata : '0;
    assign data_rdata   = resetn ? out_rdata : '0;

    assign proto_err = proto_err_q;

    // A full stall drops out_req, so the lock is neither set nor cleared while full.
    always_comb begin
        lock_valid_d = lock_valid_q;
        lock_id_d    = lock_id_q;
        rr_last_d    = rr_last_q;
        proto_err_d  = proto_err_q | (resp & empty);
        if (out_req && !out_addr_ok) begin
            lock_valid_d = 1'b1;
            lock_id_d    = grant;
        end else if (accept) begin
            lock_valid_d = 1'b0;
        end
        if (RR && accept) begin
            rr_last_d = grant;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_valid_q <= 1'b0;
            lock_id_q    <= ID_INST;
            rr_last_q    <= ID_INST;
            proto_err_q  <= 1'b0;
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
            rr_last_q    <= rr_last_d;
            proto_err_q  <= proto_err_d;
        end
    end

    arb_id_fifo #(
        .DEPTH      (MAX_OUTS)
    ) u_id_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push_i     (accept),
        .push_id_i  (grant),
        .pop_i      (pop),
        .head_id_o  (head_id),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (outs_cnt)
    );

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one downstream SRAM-like port (req/addr_ok/data_ok) between the instruction-fetch requester and the MEM-stage data requester.
- Arbitrates new requests, holds the grant stable until address acceptance, and tracks outstanding transactions in acceptance order.
- Routes each data_ok/rdata back to the requester that owns it.
- Sits between the pipeline core and the AXI bridge.

Parameters:
- MAX_OUTS, 4, maximum accepted-but-unreturned transactions; power of 2, range 2..16.
- RR, 0, 0 = fixed priority with data over inst; 1 = round-robin, toggled after each accepted request.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous reset, active-low
inst_req  in  1  fetch request; held until inst_addr_ok
inst_size  in  2  0=byte, 1=half, 2=word
inst_addr  in  32  fetch address
inst_addr_ok  out  1  fetch request accepted
inst_data_ok  out  1  fetch data returned
inst_rdata  out  32  fetch data
data_req  in  1  load/store request; held until data_addr_ok
data_wr  in  1  1 = store
data_size  in  2  as inst_size
data_addr  in  32  access address
data_wstrb  in  4  byte enables
data_wdata  in  32  store data
data_addr_ok  out  1  request accepted
data_data_ok  out  1  load data or store completion
data_rdata  out  32  load data
out_req  out  1  downstream request
out_wr  out  1  downstream write
out_size  out  2  downstream size
out_addr  out  32  downstream address
out_wstrb  out  4  downstream byte enables
out_wdata  out  32  downstream write data
out_addr_ok  in  1  downstream accepted
out_data_ok  in  1  downstream response, strictly in acceptance order, at least 1 cycle after its addr_ok
out_rdata  in  32  downstream data
outs_cnt  out  $clog2(MAX_OUTS)+1  outstanding count
proto_err  out  1  sticky: out_data_ok while nothing outstanding

Behaviour:
- Reset, asynchronous on resetn low:
  - count=0, FIFO pointers=0, lock_valid=0, rr_last=inst, proto_err=0.
  - Every output reads 0 during reset.
- Grant, combinational, computed only when lock_valid=0:
  - RR=0: data_req wins, else inst_req.
  - RR=1: when both request, the one not in rr_last wins.
  - When lock_valid=1, grant = lock_id.
- Full condition: count==MAX_OUTS forces out_req=0, drives both addr_ok to 0, and leaves the lock untouched.
- Mux: out_req = granted requester's req & ~full. out_wr, size, addr, wstrb and wdata come from the granted side. Inst drives wr=0, wstrb=0, wdata=0.
- Address handshake: x_addr_ok = out_addr_ok & out_req & (grant==x). The loser sees addr_ok=0.
- Lock register:
  - Sets lock_valid=1 and lock_id=grant when out_req & ~out_addr_ok.
  - Clears when out_req & out_addr_ok.
  - The grant never switches while a request is pending. This is legal because requesters hold req until addr_ok.
- Accept (out_req & out_addr_ok): push grant id into the ID FIFO at wptr. wptr wraps modulo MAX_OUTS. When RR=1, rr_last=grant.
- Response (out_data_ok):
  - With count>0: head id selects which x_data_ok pulses (1 cycle, combinational from out_data_ok); then pop.
  - out_rdata is broadcast to both x_rdata. Only the selected data_ok is asserted.
- Both events in one cycle: push and pop together leave count unchanged, and both pointers advance.
- out_data_ok with count==0: ignored, no pop, no data_ok pulse, proto_err<=1 held until reset.
- Latency: zero added cycles on both address and response paths; the block only adds combinational mux delay.
- Reset mid-transaction: FIFO contents are discarded, and the downstream must also be reset by the same resetn.

Decomposition:
- Package cpu_bus_pkg: ID_INST=1'b0, ID_DATA=1'b1, SIZE_BYTE/HALF/WORD encodings, SRAM_AW=32, SRAM_DW=32.
- One sub-module, arb_id_fifo:
  - MAX_OUTS×1-bit ring with push/pop/full/empty/count and async active-low reset.
  - The top holds only grant/lock/RR logic and muxes.

Test Plan:
- Both requests in cycle 0, RR=0, out_addr_ok=1 → data_addr_ok=1, inst_addr_ok=0. Cycle 1: inst accepted. Responses D then I, returned on cycles 3 and 4 → data_data_ok@3, inst_data_ok@4, outs_cnt 0→1→2→1→0.
- inst_req alone with out_addr_ok=0 for 3 cycles; data_req rises in cycle 1 → out_addr stays inst_addr until accept in cycle 3, then data is granted in cycle 4.
- MAX_OUTS=4: 4 accepts with no responses → outs_cnt=4, out_req=0 while requests are pending. One out_data_ok → next-cycle accept allowed.
- Accept and out_data_ok in the same cycle with count=2 → outs_cnt stays 2, and the correct head id is returned.
- RR=1 with both continuously requesting and out_addr_ok=1 → grants alternate D,I,D,I. Response ids match order across a 6-transaction wrap.
- out_data_ok with count=0 → no x_data_ok and proto_err=1. Assert resetn=0 mid-burst → outs_cnt=0 and proto_err=0 asynchronously.
